// File: rtl/sram_burst_packer_pkg.sv
// Shared types and constants for the SRAM burst packer: FSM states, burst lane count,
// and the frame-length legality rule.
package sram_burst_packer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  localparam int unsigned Lanes = 4;
  localparam int unsigned LaneW = $clog2(Lanes);

  // Frames must pack into whole bursts and fit the buffer without address wrap.
  function automatic bit frame_len_ok(input int unsigned frame_len, input int unsigned depth);
    return (depth % Lanes == 0) && (frame_len % Lanes == 0) &&
           (frame_len >= Lanes) && (frame_len <= depth);
  endfunction

endpackage

// File: rtl/sram_burst_packer.sv
// Packs a valid/ready sample stream into 4-lane SRAM write bursts, flushing a zero-padded
// final group and holding in DONE until the downstream reader releases the frame.
module sram_burst_packer
  import sram_burst_packer_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned ADDRB     = $clog2(DEPTH),
  parameter int unsigned FRAME_LEN = DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_release,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             o_ena,
  output logic             o_wea,
  output logic [ADDRB-1:0] o_addr,
  output logic [WIDTH-1:0] o_dina_0,
  output logic [WIDTH-1:0] o_dina_1,
  output logic [WIDTH-1:0] o_dina_2,
  output logic [WIDTH-1:0] o_dina_3,
  output logic [ADDRB:0]   o_count,
  output logic             o_busy,
  output logic             o_done
);

  if (!frame_len_ok(FRAME_LEN, DEPTH)) begin : g_bad_cfg
    $fatal(1, "sram_burst_packer: illegal FRAME_LEN/DEPTH combination");
  end

  localparam logic [ADDRB:0]   FrameLenC = (ADDRB + 1)'(FRAME_LEN);
  localparam logic [ADDRB-1:0] BaseStep  = ADDRB'(Lanes);

  state_e                        state_q, state_d;
  logic [LaneW-1:0]              lane_q, lane_d;
  logic [Lanes-1:0][WIDTH-1:0]   stage_q, stage_d;
  logic [Lanes-1:0][WIDTH-1:0]   dina_q, dina_d;
  logic [ADDRB:0]                count_q, count_d;
  logic [ADDRB-1:0]              base_q, base_d;
  logic [ADDRB-1:0]              addr_q, addr_d;
  logic                          wea_q, wea_d;

  logic           accept;
  logic           frame_end;
  logic [ADDRB:0] count_inc;

  assign accept    = s_valid && (state_q == StFill);
  assign count_inc = count_q + 1'b1;
  assign frame_end = s_last || (count_inc == FrameLenC);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    stage_d = stage_q;
    dina_d  = dina_q;
    count_d = count_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wea_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StFill;
          lane_d  = '0;
          count_d = '0;
          base_d  = '0;
          addr_d  = '0;
        end
      end
      StFill: begin
        if (accept) begin
          stage_d[lane_q] = s_data;
          count_d         = count_inc;
          lane_d          = lane_q + 1'b1;
          if ((lane_q == LaneW'(Lanes - 1)) || frame_end) begin
            // Lanes below the current index come from staging, the current one bypasses
            // staging, and anything above it is padding on a short final group.
            for (int i = 0; i < Lanes; i++) begin
              if (i < int'(lane_q)) begin
                dina_d[i] = stage_q[i];
              end else if (i == int'(lane_q)) begin
                dina_d[i] = s_data;
              end else begin
                dina_d[i] = '0;
              end
            end
            wea_d  = 1'b1;
            addr_d = base_q;
            base_d = base_q + BaseStep;
            lane_d = '0;
            if (frame_end) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        if (i_release) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
      stage_q <= '0;
      dina_q  <= '0;
      count_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wea_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      stage_q <= stage_d;
      dina_q  <= dina_d;
      count_q <= count_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wea_q   <= wea_d;
    end
  end

  assign s_ready  = (state_q == StFill);
  assign o_busy   = (state_q == StFill);
  assign o_done   = (state_q == StDone);
  assign o_wea    = wea_q;
  assign o_ena    = wea_q;
  assign o_addr   = addr_q;
  assign o_count  = count_q;
  assign o_dina_0 = dina_q[0];
  assign o_dina_1 = dina_q[1];
  assign o_dina_2 = dina_q[2];
  assign o_dina_3 = dina_q[3];

endmodule

// File: tb/tb_sram_burst_packer.sv
// Directed and randomized frames for sram_burst_packer, checked against a burst-list model
// built from the sample sequence of each frame.
module tb_sram_burst_packer;

  localparam int unsigned WIDTH     = 10;
  localparam int unsigned DEPTH     = 128;
  localparam int unsigned ADDRB     = 7;
  localparam int unsigned FRAME_LEN = 128;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             i_release = 1'b0;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             o_ena;
  logic             o_wea;
  logic [ADDRB-1:0] o_addr;
  logic [WIDTH-1:0] o_dina_0, o_dina_1, o_dina_2, o_dina_3;
  logic [ADDRB:0]   o_count;
  logic             o_busy;
  logic             o_done;

  sram_burst_packer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDRB    (ADDRB),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_release(i_release),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .o_ena    (o_ena),
    .o_wea    (o_wea),
    .o_addr   (o_addr),
    .o_dina_0 (o_dina_0),
    .o_dina_1 (o_dina_1),
    .o_dina_2 (o_dina_2),
    .o_dina_3 (o_dina_3),
    .o_count  (o_count),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ADDRB-1:0]   addr;
    logic [4*WIDTH-1:0] lanes;
    logic               ena;
    logic               done;
  } burst_t;

  burst_t           obs_q[$];
  logic [WIDTH-1:0] samp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;

  // Bursts are captured 1 time unit after each rising edge.
  always @(posedge i_clk) begin
    #1;
    if (o_wea === 1'b1) begin
      obs_q.push_back('{addr: o_addr, lanes: {o_dina_3, o_dina_2, o_dina_1, o_dina_0},
                        ena: o_ena, done: o_done});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_ena"}, o_ena, 0);
    chk({tag, "_wea"}, o_wea, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_dina"}, {o_dina_3, o_dina_2, o_dina_1, o_dina_0}, 0);
  endtask

  task automatic start_frame();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_count", o_count, 0);
  endtask

  task automatic release_frame();
    @(negedge i_clk);
    i_release = 1'b1;
    @(negedge i_clk);
    i_release = 1'b0;
    chk("release_done", o_done, 0);
    chk("release_ready", s_ready, 0);
  endtask

  // Drive samp_q with s_valid asserted pct% of cycles; optionally poke i_start/i_release mid-frame.
  task automatic drive_frame(input bit use_last, input int pct, input bit poke);
    int idx = 0;
    int cyc = 0;
    while (idx < samp_q.size() && cyc < 4000) begin
      @(negedge i_clk);
      cyc++;
      i_start   = 1'b0;
      i_release = 1'b0;
      if (s_ready !== 1'b1) begin
        chk("fill_ready", s_ready, 1);
      end
      if (poke && idx == 5) begin
        i_start   = 1'b1;
        i_release = 1'b1;
      end
      if ($urandom_range(99) < pct) begin
        s_valid = 1'b1;
        s_data  = samp_q[idx];
        s_last  = use_last && (idx == samp_q.size() - 1);
        idx++;
      end else begin
        s_valid = 1'b0;
        s_data  = WIDTH'($urandom);
        s_last  = 1'($urandom);
      end
    end
    @(negedge i_clk);
    s_valid   = 1'b0;
    s_last    = 1'b0;
    i_start   = 1'b0;
    i_release = 1'b0;
    chk("frame_cycle_budget", idx == samp_q.size(), 1);
  endtask

  // Reference: n accepted samples (capped at FRAME_LEN) -> ceil(n/4) bursts at 4k, zero-padded.
  task automatic check_frame(input string tag);
    int      n = (samp_q.size() > FRAME_LEN) ? FRAME_LEN : samp_q.size();
    int      nb = (n + 3) / 4;
    burst_t  exp_b;
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_count"}, o_count, n);
    chk({tag, "_nbursts"}, obs_q.size(), nb);
    for (int k = 0; k < nb && k < obs_q.size(); k++) begin
      exp_b.addr = ADDRB'(4 * k);
      exp_b.ena  = 1'b1;
      exp_b.done = (k == nb - 1);
      for (int j = 0; j < 4; j++) begin
        exp_b.lanes[j*WIDTH +: WIDTH] = (4 * k + j < n) ? samp_q[4*k+j] : '0;
      end
      chk($sformatf("%s_burst%0d", tag, k), obs_q[k], exp_b);
    end
    obs_q.delete();
  endtask

  // s_valid held in DONE and then IDLE must not be consumed.
  task automatic check_idle_hold(input int exp_count);
    s_valid = 1'b1;
    s_data  = WIDTH'($urandom);
    repeat (2) @(negedge i_clk);
    chk("done_ready", s_ready, 0);
    chk("done_count_hold", o_count, exp_count);
    s_valid = 1'b0;
    release_frame();
    s_valid = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("idle_ready", s_ready, 0);
    chk("idle_count_hold", o_count, exp_count);
    chk("idle_no_burst", obs_q.size(), 0);
    s_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    chk_reset_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk_reset_outputs("post_reset");

    // Full frame, continuous, ends on FRAME_LEN.
    start_frame();
    samp_q.delete();
    for (int i = 0; i < 128; i++) samp_q.push_back(WIDTH'(i));
    drive_frame(1'b0, 100, 1'b0);
    check_frame("full");
    @(negedge i_clk);
    chk("hold_wea", o_wea, 0);
    chk("hold_addr", o_addr, 124);
    chk("hold_dina3", o_dina_3, 127);
    check_idle_hold(128);

    // Short frame ending mid-group.
    start_frame();
    samp_q.delete();
    for (int i = 10; i < 16; i++) samp_q.push_back(WIDTH'(i));
    drive_frame(1'b1, 100, 1'b0);
    check_frame("short6");
    release_frame();

    // s_last exactly on a group boundary.
    start_frame();
    samp_q.delete();
    for (int i = 0; i < 8; i++) samp_q.push_back(WIDTH'($urandom));
    drive_frame(1'b1, 100, 1'b0);
    check_frame("edge8");
    release_frame();

    // Gappy valid, with stray i_start/i_release mid-frame.
    start_frame();
    samp_q.delete();
    for (int i = 0; i < 12; i++) samp_q.push_back(WIDTH'($urandom));
    drive_frame(1'b1, 50, 1'b1);
    check_frame("gappy12");
    release_frame();

    // Asynchronous reset after 3 accepted samples.
    start_frame();
    samp_q.delete();
    for (int i = 0; i < 3; i++) samp_q.push_back(WIDTH'($urandom));
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      s_valid = 1'b1;
      s_data  = samp_q[i];
    end
    @(posedge i_clk);
    #2;
    s_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    chk("async_reset_no_burst", obs_q.size(), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    start_frame();
    samp_q.delete();
    for (int i = 0; i < 5; i++) samp_q.push_back(WIDTH'($urandom));
    drive_frame(1'b1, 100, 1'b0);
    check_frame("after_reset");
    release_frame();

    // Random frames of random length and valid density.
    for (int f = 0; f < 6; f++) begin
      int len;
      len = (f == 5) ? 128 : $urandom_range(1, 60);
      start_frame();
      samp_q.delete();
      for (int i = 0; i < len; i++) samp_q.push_back(WIDTH'($urandom));
      drive_frame(1'b1, $urandom_range(30, 100), 1'b0);
      check_frame($sformatf("rand%0d", f));
      release_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
